// File: rtl/alu_result_accumulator_pkg.sv
// rtl/alu_result_accumulator_pkg.sv - shared widths, state encoding and saturation bounds
package alu_result_accumulator_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ACC_W  = 24;
  localparam int DEF_LEN_W  = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [15:0] SAT_MIN = 16'sh8000;

endpackage

// File: rtl/sat_clamp.sv
// rtl/sat_clamp.sv - combinational signed clamp from a wide value to OUT_W bits with overflow flag
module sat_clamp
  import alu_result_accumulator_pkg::*;
#(
  parameter int                       IN_W  = DEF_ACC_W,
  parameter int                       OUT_W = DEF_DATA_W,
  parameter logic signed [OUT_W-1:0]  MAX_V = SAT_MAX,
  parameter logic signed [OUT_W-1:0]  MIN_V = SAT_MIN
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    ovf
);

  localparam logic signed [IN_W-1:0] MAX_EXT = IN_W'(MAX_V);
  localparam logic signed [IN_W-1:0] MIN_EXT = IN_W'(MIN_V);

  always_comb begin
    dout = din[OUT_W-1:0];
    ovf  = 1'b0;
    if (din > MAX_EXT) begin
      dout = MAX_V;
      ovf  = 1'b1;
    end else if (din < MIN_EXT) begin
      dout = MIN_V;
      ovf  = 1'b1;
    end
  end

endmodule

// File: rtl/alu_result_accumulator.sv
// rtl/alu_result_accumulator.sv - sums a programmed batch of ALU results into one saturated sample
module alu_result_accumulator
  import alu_result_accumulator_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W:0]   in_y,
  input  logic              in_co,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sat,
  output logic [LEN_W-1:0]  out_carry_cnt,
  output logic              busy
);

  logic [1:0]               state;
  logic [1:0]               state_nxt;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic signed [ACC_W-1:0]  sample_ext;
  logic [LEN_W-1:0]         cnt;
  logic [LEN_W-1:0]         cnt_nxt;
  logic [LEN_W-1:0]         target;
  logic [LEN_W-1:0]         carry_cnt;
  logic [LEN_W-1:0]         carry_nxt;
  logic                     beat;
  logic                     last_beat;
  logic signed [DATA_W-1:0] clamp_data;
  logic                     clamp_ovf;
  logic                     unused_y_msb;

  // The ALU's extra Y bit carries no sign information for this consumer.
  assign unused_y_msb = in_y[DATA_W];
  assign sample_ext   = {{(ACC_W-DATA_W){in_y[DATA_W-1]}}, in_y[DATA_W-1:0]};
  assign acc_nxt      = acc + sample_ext;
  assign cnt_nxt      = cnt + LEN_W'(1);
  assign carry_nxt    = carry_cnt + LEN_W'(in_co);
  assign beat         = in_valid & in_ready;
  assign last_beat    = beat && (cnt_nxt == target);

  sat_clamp #(
    .IN_W  (ACC_W),
    .OUT_W (DATA_W)
  ) u_sat_clamp (
    .din  (acc_nxt),
    .dout (clamp_data),
    .ovf  (clamp_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (len != '0) ? ACC : DONE;
      ACC:  if (last_beat) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ACC);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // Result registers only change at batch completion so they survive the DONE->IDLE handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc           <= '0;
      cnt           <= '0;
      target        <= '0;
      carry_cnt     <= '0;
      out_data      <= '0;
      out_sat       <= 1'b0;
      out_carry_cnt <= '0;
    end else begin
      if (state == IDLE && start) begin
        if (len != '0) begin
          target    <= len;
          acc       <= '0;
          cnt       <= '0;
          carry_cnt <= '0;
        end else begin
          out_data      <= '0;
          out_sat       <= 1'b0;
          out_carry_cnt <= '0;
        end
      end
      if (beat) begin
        acc       <= acc_nxt;
        cnt       <= cnt_nxt;
        carry_cnt <= carry_nxt;
        if (last_beat) begin
          out_data      <= clamp_data;
          out_sat       <= clamp_ovf;
          out_carry_cnt <= carry_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_result_accumulator.sv
// tb/tb_alu_result_accumulator.sv - scoreboard bench for alu_result_accumulator
module tb_alu_result_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  len = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [16:0] in_y = '0;
  logic        in_co = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_sat;
  logic [7:0]  out_carry_cnt;
  logic        busy;

  typedef struct packed {
    logic [15:0] data;
    logic        sat;
    logic [7:0]  carry;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  alu_result_accumulator dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .len           (len),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_y          (in_y),
    .in_co         (in_co),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_sat       (out_sat),
    .out_carry_cnt (out_carry_cnt),
    .busy          (busy)
  );

  function automatic exp_t predict(input logic [16:0] ys[$], input logic cs[$]);
    longint s = 0;
    int     c = 0;
    exp_t   e;
    foreach (ys[i]) s += longint'($signed(ys[i][15:0]));
    foreach (cs[i]) c += int'(cs[i]);
    if (s > 32767) begin
      e.data = 16'h7FFF; e.sat = 1'b1;
    end else if (s < -32768) begin
      e.data = 16'h8000; e.sat = 1'b1;
    end else begin
      e.data = s[15:0]; e.sat = 1'b0;
    end
    e.carry = 8'(c);
    return e;
  endfunction

  task automatic do_start(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_beats(input logic [16:0] ys[$], input logic cs[$], output bit ok);
    int t;
    ok = 1'b1;
    foreach (ys[i]) begin
      in_valid = 1'b1;
      in_y     = ys[i];
      in_co    = cs[i];
      t = 0;
      while (!in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) ok = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_co    = 1'b0;
  endtask

  task automatic wait_out(output bit ok);
    int t = 0;
    while (!out_valid && t < 600) begin
      @(negedge clk);
      t++;
    end
    ok = out_valid;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid, out_data, out_sat, out_carry_cnt, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b data=%h sat=%b cc=%0d busy=%b, want all 0",
               in_ready, out_valid, out_data, out_sat, out_carry_cnt, busy);
    end
    rst = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({in_ready, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_ignores_valid: got rdy=%b busy=%b, want 0 0", in_ready, busy);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_basic();
    logic [16:0] ys[$];
    logic        cs[$];
    bit          ok;
    exp_t        e;
    ys = '{17'd100, 17'h1FFD8, 17'd5};
    cs = '{1'b0, 1'b1, 1'b1};
    sb.push_back(predict(ys, cs));
    do_start(8'd3);
    send_beats(ys, cs, ok);
    n_cmp++;
    if (!ok || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_latency: got out_valid=%b accepted=%0d, want out_valid=1 one cycle after last beat", out_valid, ok);
    end
    wait_out(ok);
    e = sb.pop_front();
    n_cmp++;
    if (out_data !== e.data || out_sat !== e.sat || out_carry_cnt !== e.carry) begin
      n_fail++;
      $display("FAIL basic_result: got data=%0d sat=%b cc=%0d, want data=%0d sat=%b cc=%0d",
               $signed(out_data), out_sat, out_carry_cnt, $signed(e.data), e.sat, e.carry);
    end
    handshake();
    n_cmp++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== e.data) begin
      n_fail++;
      $display("FAIL basic_after_hs: got busy=%b vld=%b data=%0d, want 0 0 %0d",
               busy, out_valid, $signed(out_data), $signed(e.data));
    end
  endtask

  task automatic test_saturation();
    logic [16:0] ys[$];
    logic        cs[$];
    bit          ok;
    exp_t        e;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) ys = '{17'h07FFF, 17'h00001};
      else        ys = '{17'h08000, 17'h0FFFF};
      cs = '{1'b0, 1'b0};
      sb.push_back(predict(ys, cs));
      do_start(8'd2);
      send_beats(ys, cs, ok);
      wait_out(ok);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || out_data !== e.data || out_sat !== e.sat) begin
        n_fail++;
        $display("FAIL saturation_%0d: got vld=%0d data=%0d sat=%b, want data=%0d sat=%b",
                 k, ok, $signed(out_data), out_sat, $signed(e.data), e.sat);
      end
      handshake();
    end
  endtask

  task automatic test_backpressure();
    logic [16:0] ys[$];
    logic        cs[$];
    logic        pat[$];
    bit          ok;
    int          k = 0;
    exp_t        e;
    ys  = '{17'd1, 17'd2, 17'd3, 17'd4};
    cs  = '{1'b1, 1'b0, 1'b0, 1'b1};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    sb.push_back(predict(ys, cs));
    do_start(8'd4);
    foreach (pat[i]) begin
      in_valid = pat[i];
      in_y     = ys[k];
      in_co    = cs[k];
      @(negedge clk);
      if (pat[i]) k++;
    end
    in_valid = 1'b0;
    e = sb.pop_front();
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== e.data || out_carry_cnt !== e.carry) begin
        n_fail++;
        $display("FAIL backpressure_hold_%0d: got vld=%b data=%0d cc=%0d, want 1 %0d %0d",
                 c, out_valid, $signed(out_data), out_carry_cnt, $signed(e.data), e.carry);
      end
      @(negedge clk);
    end
    handshake();
    n_cmp++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_idle: got busy=%b vld=%b, want 0 0", busy, out_valid);
    end
    ok = 1'b1;
  endtask

  task automatic test_mid_reset();
    logic [16:0] ys[$];
    logic        cs[$];
    bit          ok;
    exp_t        e;
    ys = '{17'd1000, 17'd2000};
    cs = '{1'b1, 1'b1};
    do_start(8'd5);
    send_beats(ys, cs, ok);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, out_data, out_sat, out_carry_cnt, busy} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_async: got rdy=%b vld=%b data=%h sat=%b cc=%0d busy=%b, want all 0",
               in_ready, out_valid, out_data, out_sat, out_carry_cnt, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ys = '{17'h1FFF9};
    cs = '{1'b0};
    sb.push_back(predict(ys, cs));
    do_start(8'd1);
    send_beats(ys, cs, ok);
    wait_out(ok);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || out_data !== e.data || out_sat !== e.sat || out_carry_cnt !== e.carry) begin
      n_fail++;
      $display("FAIL mid_reset_no_residue: got data=%0d sat=%b cc=%0d, want %0d %b %0d",
               $signed(out_data), out_sat, out_carry_cnt, $signed(e.data), e.sat, e.carry);
    end
    handshake();
  endtask

  task automatic test_len_zero();
    logic [16:0] ys[$];
    logic        cs[$];
    bit          ok;
    exp_t        e;
    sb.push_back('0);
    do_start(8'd0);
    e = sb.pop_front();
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== e.data || out_sat !== e.sat || out_carry_cnt !== e.carry) begin
      n_fail++;
      $display("FAIL len_zero: got vld=%b data=%0d sat=%b cc=%0d, want 1 0 0 0",
               out_valid, $signed(out_data), out_sat, out_carry_cnt);
    end
    do_start(8'd5);
    n_cmp++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_in_done: got vld=%b busy=%b, want 1 1", out_valid, busy);
    end
    handshake();
    ys = '{17'd9, 17'd11};
    cs = '{1'b1, 1'b0};
    sb.push_back(predict(ys, cs));
    do_start(8'd2);
    do_start(8'd9);
    send_beats(ys, cs, ok);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || out_valid !== 1'b1 || out_data !== e.data || out_carry_cnt !== e.carry) begin
      n_fail++;
      $display("FAIL start_in_acc: got vld=%b data=%0d cc=%0d, want 1 %0d %0d",
               out_valid, $signed(out_data), out_carry_cnt, $signed(e.data), e.carry);
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    logic [16:0] ys[$];
    logic        cs[$];
    bit          ok;
    exp_t        e;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin ys = '{17'd300};   cs = '{1'b1}; end
      else        begin ys = '{17'h1FFFF}; cs = '{1'b0}; end
      sb.push_back(predict(ys, cs));
      do_start(8'd1);
      send_beats(ys, cs, ok);
      wait_out(ok);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || out_data !== e.data || out_sat !== e.sat || out_carry_cnt !== e.carry) begin
        n_fail++;
        $display("FAIL back_to_back_%0d: got data=%0d sat=%b cc=%0d, want %0d %b %0d",
                 k, $signed(out_data), out_sat, out_carry_cnt, $signed(e.data), e.sat, e.carry);
      end
      handshake();
    end
  endtask

  task automatic test_long_batch();
    logic [16:0] ys[$];
    logic        cs[$];
    bit          ok;
    exp_t        e;
    ys = '{17'h10005, 17'h00003};
    cs = '{1'b0, 1'b0};
    sb.push_back(predict(ys, cs));
    do_start(8'd2);
    send_beats(ys, cs, ok);
    wait_out(ok);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || out_data !== e.data || out_sat !== e.sat) begin
      n_fail++;
      $display("FAIL y_msb_ignored: got data=%0d sat=%b, want %0d %b",
               $signed(out_data), out_sat, $signed(e.data), e.sat);
    end
    handshake();
    ys.delete();
    cs.delete();
    for (int i = 0; i < 255; i++) begin
      ys.push_back((i % 2 == 1) ? 17'h18000 : 17'h08000);
      cs.push_back(1'b1);
    end
    sb.push_back(predict(ys, cs));
    do_start(8'd255);
    send_beats(ys, cs, ok);
    wait_out(ok);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || out_data !== e.data || out_sat !== e.sat || out_carry_cnt !== e.carry) begin
      n_fail++;
      $display("FAIL long_batch: got vld=%0d data=%0d sat=%b cc=%0d, want %0d %b %0d",
               ok, $signed(out_data), out_sat, out_carry_cnt, $signed(e.data), e.sat, e.carry);
    end
    handshake();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_mid_reset();
    test_len_zero();
    test_back_to_back();
    test_long_batch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
